// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction memory,
// and buffers fetched words in a small FIFO with a valid/ready handshake to decode.

module fetch_queue_chk #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [$clog2(DEPTH):0]     occupancy_i
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push_i && (occupancy_i == DEPTH_C) && !pop_i));

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop_i && (occupancy_i == {CW{1'b0}})));

    a_occ_bound: assert property (@(posedge clk) disable iff (reset)
        occupancy_i <= DEPTH_C);
endmodule

module fetch_queue #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter int          MEM_WORDS = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_rd,
    input  logic                       fetch_en,
    input  logic                       branch_taken,
    input  logic [31:0]                branch_target,
    output logic [31:0]                instr,
    output logic [31:0]                instr_pc,
    output logic [31:0]                instr_pc8,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic                       fetch_fault,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [32:0]   PC_LIMIT = 33'(4 * MEM_WORDS);

    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          fault_q, fault_d;
    logic [31:0]   word_q [DEPTH];
    logic [31:0]   addr_q [DEPTH];

    logic          pop_s;
    logic          push_s;
    logic          in_range_s;

    assign imem_addr  = pc_q;
    assign in_range_s = ({1'b0, pc_q} < PC_LIMIT);
    assign pop_s      = (count_q != {CW{1'b0}}) && instr_ready;
    assign push_s     = fetch_en && !branch_taken && !fault_q && in_range_s
                        && ((count_q < DEPTH_C) || pop_s);

    // Next-state for PC, FIFO pointers and fault flag; a redirect overrides everything.
    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        fault_d = fault_q;
        if (branch_taken) begin
            pc_d    = branch_target & ~32'h0000_0003;
            head_d  = {AW{1'b0}};
            tail_d  = {AW{1'b0}};
            count_d = {CW{1'b0}};
            fault_d = 1'b0;
        end else begin
            if (push_s) begin
                pc_d   = pc_q + 32'd4;
                tail_d = tail_q + AW'(1'b1);
            end else begin
                pc_d   = pc_q;
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + AW'(1'b1);
            end else begin
                head_d = head_q;
            end
            count_d = count_q + CW'(push_s) - CW'(pop_s);
            if (fetch_en && !in_range_s) begin
                fault_d = 1'b1;
            end else begin
                fault_d = fault_q;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            head_q  <= {AW{1'b0}};
            tail_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            fault_q <= fault_d;
        end
    end

    // FIFO storage: each entry holds the fetched word and the PC it came from.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= 32'h0000_0000;
                addr_q[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            word_q[tail_q] <= imem_rd;
            addr_q[tail_q] <= pc_q;
        end else begin
            word_q[tail_q] <= word_q[tail_q];
            addr_q[tail_q] <= addr_q[tail_q];
        end
    end

    // Head presentation; an empty FIFO shows 0/0/8.
    always_comb begin
        instr_valid = (count_q != {CW{1'b0}});
        instr       = 32'h0000_0000;
        instr_pc    = 32'h0000_0000;
        instr_pc8   = 32'h0000_0008;
        if (instr_valid) begin
            instr     = word_q[head_q];
            instr_pc  = addr_q[head_q];
            instr_pc8 = addr_q[head_q] + 32'd8;
        end else begin
            instr     = 32'h0000_0000;
            instr_pc  = 32'h0000_0000;
            instr_pc8 = 32'h0000_0008;
        end
    end

    assign fetch_fault = fault_q;
    assign occupancy   = count_q;

    fetch_queue_chk #(.DEPTH(DEPTH)) u_chk (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .occupancy_i (count_q)
    );
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model of the fetch stage.

module tb_fetch_queue;
    localparam int DEPTH     = 2;
    localparam int MEM_WORDS = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        fetch_en;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc8;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_fault;
    logic [1:0]  occupancy;

    fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_rd       (imem_rd),
        .fetch_en      (fetch_en),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_pc8     (instr_pc8),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .fetch_fault   (fetch_fault),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:MEM_WORDS-1];
    always_comb imem_rd = (imem_addr < 32'd1024) ? mem[imem_addr[9:2]] : 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    logic        m_fault;
    int          vectors = 0;
    int          miscompares = 0;

    logic [131:0] dut_vec;
    assign dut_vec = {imem_addr, instr_valid, instr, instr_pc, instr_pc8, occupancy, fetch_fault};

    function automatic logic [131:0] exp_vec();
        logic        v;
        logic [31:0] w;
        logic [31:0] p;
        v = (q.size() != 0);
        w = v ? q[0].w  : 32'h0;
        p = v ? q[0].pc : 32'h0;
        return {m_pc, v, w, p, p + 32'd8, 2'(q.size()), m_fault};
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc    = 32'h0;
        m_fault = 1'b0;
    endtask

    task automatic drive(input logic fe, input logic rdy, input logic bt, input logic [31:0] tgt);
        fetch_en      = fe;
        instr_ready   = rdy;
        branch_taken  = bt;
        branch_target = tgt;
    endtask

    // One clock: the model decides push/pop from the spec rules before the edge, applies after.
    task automatic step();
        bit          pop;
        bit          push;
        bit          inr;
        logic [31:0] word;
        pop  = (q.size() != 0) && instr_ready;
        inr  = (m_pc < 32'd1024);
        word = inr ? mem[m_pc[9:2]] : 32'hDEAD_BEEF;
        push = fetch_en && !branch_taken && !m_fault && inr && ((q.size() < DEPTH) || pop);
        @(posedge clk);
        if (branch_taken) begin
            q.delete();
            m_pc    = branch_target & ~32'h3;
            m_fault = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(ent_t'{w: word, pc: m_pc});
                m_pc = m_pc + 32'd4;
            end
            if (fetch_en && !inr) m_fault = 1'b1;
        end
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        #2;
        model_reset();
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", dut_vec, exp_vec());
        end
        vectors++;
        if (instr_pc8 !== 32'd8) begin
            miscompares++;
            $display("FAIL reset_pc8: got %h expected 00000008", instr_pc8);
        end
        release_reset();
    endtask

    task automatic test_stream();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL stream c%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
            vectors++;
            if (instr !== 32'hE000_0000 + 32'(i) || instr_pc8 !== 32'(4 * i + 8)) begin
                miscompares++;
                $display("FAIL stream_seq c%0d: got %h/%h expected %h/%h",
                         i, instr, instr_pc8, 32'hE000_0000 + 32'(i), 32'(4 * i + 8));
            end
        end
    endtask

    task automatic test_backpressure();
        reset = 1'b1;
        #2;
        model_reset();
        release_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL bp_hold c%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        vectors++;
        if (occupancy !== 2'd2 || imem_addr !== 32'd8) begin
            miscompares++;
            $display("FAIL bp_full: got occ %0d pc %h expected occ 2 pc 00000008", occupancy, imem_addr);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (!instr_valid || instr_pc !== 32'(4 * i)) begin
                miscompares++;
                $display("FAIL bp_drain c%0d: got v%0d pc %h expected v1 pc %h", i, instr_valid, instr_pc, 32'(4 * i));
            end
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL bp_release c%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_flush();
        reset = 1'b1;
        #2;
        model_reset();
        release_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0043);
        step();
        vectors++;
        if (occupancy !== 2'd0 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush: got occ %0d pc %h v%0d expected occ 0 pc 00000040 v0", occupancy, imem_addr, instr_valid);
        end
        branch_taken = 1'b0;
        step();
        vectors++;
        if (instr_pc !== 32'h40 || instr_valid !== 1'b1 || instr !== 32'hE000_0010) begin
            miscompares++;
            $display("FAIL flush_resume: got pc %h v%0d w %h expected pc 00000040 v1 w e0000010", instr_pc, instr_valid, instr);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL flush_after c%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_fault();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_03F8);
        step();
        branch_taken = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL fault_run c%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        vectors++;
        if (fetch_fault !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'h400) begin
            miscompares++;
            $display("FAIL fault_set: got f%0d v%0d pc %h expected f1 v0 pc 00000400", fetch_fault, instr_valid, imem_addr);
        end
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0010);
        step();
        vectors++;
        if (fetch_fault !== 1'b0 || imem_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL fault_clear: got f%0d pc %h expected f0 pc 00000010", fetch_fault, imem_addr);
        end
        branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL fault_resume c%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_midreset();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL midreset: got %h expected %h", dut_vec, exp_vec());
        end
        release_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL midreset_restart c%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_fetch_en();
        logic [31:0] held;
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        held = imem_addr;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec() || imem_addr !== held) begin
                miscompares++;
                $display("FAIL fe_low c%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        fetch_en = 1'b1;
        step();
        vectors++;
        if (instr_pc !== held || instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL fe_resume: got pc %h v%0d expected pc %h v1", instr_pc, instr_valid, held);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < MEM_WORDS; k++) mem[k] = $urandom;
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 15) == 0, 32'($urandom_range(0, 32'h420)));
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL random c%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        for (int k = 0; k < MEM_WORDS; k++) mem[k] = 32'hE000_0000 + 32'(k);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_fault();
        test_midreset();
        test_fetch_en();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
